// File: rtl/vga_timing_pkg.sv
// Timing constants and shared types for the VGA sync generator.
// Holds the 640x480@60Hz line/frame geometry, the pixel clock divider and the count width.
// No logic; imported by the interface, the axis counter and the top level.
package vga_timing_pkg;

    localparam int COUNT_W = 10;
    typedef logic [COUNT_W-1:0] count_t;

    // 100 MHz board clock / 4 = 25 MHz pixel rate
    localparam int CLK_DIV = 4;
    localparam int DIV_W   = 2;
    typedef logic [DIV_W-1:0] div_t;

    localparam count_t H_TOTAL = 10'd800;
    localparam count_t H_SYNC  = 10'd96;
    localparam count_t H_START = 10'd144;
    localparam count_t H_END   = 10'd784;
    localparam count_t V_TOTAL = 10'd525;
    localparam count_t V_SYNC  = 10'd2;
    localparam count_t V_START = 10'd35;
    localparam count_t V_END   = 10'd515;

    // One bundle of geometry so a whole timing set can be passed as a single parameter.
    typedef struct packed {
        count_t h_total;
        count_t h_sync;
        count_t h_start;
        count_t h_end;
        count_t v_total;
        count_t v_sync;
        count_t v_start;
        count_t v_end;
    } timing_t;

    localparam timing_t VGA_640X480 = '{
        h_total: H_TOTAL, h_sync: H_SYNC, h_start: H_START, h_end: H_END,
        v_total: V_TOTAL, v_sync: V_SYNC, v_start: V_START, v_end: V_END
    };

endpackage

// File: rtl/vga_sync_gen_if.sv
// VGA timing bundle: counts, syncs, visible-window flag and timing strobes.
// Pure wiring, no latency.
// No backpressure: the source free-runs, consumers sample every clk.
// Signals: hCount/vCount (10b), hSync/vSync (active low), bright, pix_en,
//          frame_tick, move_tick.  master = generator, slave = consumer.
interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    count_t hCount;
    count_t vCount;
    logic   hSync;
    logic   vSync;
    logic   bright;
    logic   pix_en;
    logic   frame_tick;
    logic   move_tick;

    modport master (
        output hCount, vCount, hSync, vSync, bright, pix_en, frame_tick, move_tick
    );

    modport slave (
        input hCount, vCount, hSync, vSync, bright, pix_en, frame_tick, move_tick
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One scan axis: counts on en, wraps at TOTAL, decodes sync and active window.
// Latency: count/sync/active registered together (zero relative skew); wrap is combinational.
// No backpressure: en is a strobe, the counter always accepts it.
// Ports: clk, reset (sync, active high), en in; count, sync (low while count < SYNC_LEN),
//        active (ACT_START <= count < ACT_END), wrap (en at TOTAL-1) out.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter count_t TOTAL     = H_TOTAL,
    parameter count_t SYNC_LEN  = H_SYNC,
    parameter count_t ACT_START = H_START,
    parameter count_t ACT_END   = H_END
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   en,
    output count_t count,
    output logic   sync,
    output logic   active,
    output logic   wrap
);

    count_t count_next;

    assign wrap = en && (count == TOTAL - count_t'(1));

    always_comb begin
        count_next = count;
        if (wrap) begin
            count_next = '0;
        end else if (en) begin
            count_next = count + count_t'(1);
        end
    end

    // Decoding from count_next keeps sync/active in step with the registered count.
    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            sync   <= 1'b0;
            active <= 1'b0;
        end else begin
            count  <= count_next;
            sync   <= (count_next >= SYNC_LEN);
            active <= (count_next >= ACT_START) && (count_next < ACT_END);
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA 640x480@60Hz timing generator from a 100 MHz clock, plus frame/move timing strobes.
// Latency: all outputs registered and mutually aligned; counts advance on the edge after pix_en.
// No backpressure: free-running; reset restarts the whole frame at (0,0).
// Ports: clk, reset (sync, active high); vga (master): hCount, vCount, hSync, vSync, bright,
//        pix_en, frame_tick, move_tick.
// Build option VGA_MOVE_TICK_EN: adds a frame counter and move_tick every TICK_FRAMES frames;
// without it move_tick is held at 0.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter timing_t TIMING = VGA_640X480
`ifdef VGA_MOVE_TICK_EN
    , parameter int TICK_FRAMES = 4
`endif
) (
    input  logic clk,
    input  logic reset,
    vga_sync_gen_if.master vga
);

    localparam div_t DIV_LAST = div_t'(CLK_DIV - 1);

    div_t   div;
    div_t   div_next;
    logic   pix_en_q;
    logic   frame_tick_q;

    count_t h_count;
    count_t v_count;
    logic   h_sync;
    logic   v_sync;
    logic   h_active;
    logic   v_active;
    logic   h_wrap;
    logic   v_wrap;

    assign div_next = (div == DIV_LAST) ? '0 : div + div_t'(1);

    // pix_en is registered from div_next so it is high exactly while div == CLK_DIV-1.
    // v_wrap already implies pix_en and an h wrap, so it marks the end-of-frame edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            div          <= '0;
            pix_en_q     <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            div          <= div_next;
            pix_en_q     <= (div_next == DIV_LAST);
            frame_tick_q <= v_wrap;
        end
    end

    vga_axis_counter #(
        .TOTAL     (TIMING.h_total),
        .SYNC_LEN  (TIMING.h_sync),
        .ACT_START (TIMING.h_start),
        .ACT_END   (TIMING.h_end)
    ) u_h (
        .clk    (clk),
        .reset  (reset),
        .en     (pix_en_q),
        .count  (h_count),
        .sync   (h_sync),
        .active (h_active),
        .wrap   (h_wrap)
    );

    vga_axis_counter #(
        .TOTAL     (TIMING.v_total),
        .SYNC_LEN  (TIMING.v_sync),
        .ACT_START (TIMING.v_start),
        .ACT_END   (TIMING.v_end)
    ) u_v (
        .clk    (clk),
        .reset  (reset),
        .en     (h_wrap),
        .count  (v_count),
        .sync   (v_sync),
        .active (v_active),
        .wrap   (v_wrap)
    );

`ifdef VGA_MOVE_TICK_EN
    localparam int FC_W = (TICK_FRAMES > 1) ? $clog2(TICK_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(TICK_FRAMES - 1);

    logic [FC_W-1:0] frame_cnt;
    logic            move_tick_q;

    // Counter and move_tick update on the same edge that raises frame_tick,
    // so move_tick lands in the same cycle as every TICK_FRAMES-th frame_tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt   <= '0;
            move_tick_q <= 1'b0;
        end else begin
            move_tick_q <= v_wrap && (frame_cnt == FC_LAST);
            if (v_wrap) begin
                frame_cnt <= (frame_cnt == FC_LAST) ? '0 : frame_cnt + FC_W'(1);
            end
        end
    end

    assign vga.move_tick = move_tick_q;
`else
    assign vga.move_tick = 1'b0;
`endif

    assign vga.hCount     = h_count;
    assign vga.vCount     = v_count;
    assign vga.hSync      = h_sync;
    assign vga.vSync      = v_sync;
    // Both inputs are flops updated on the same edge, so the AND is glitch-free.
    assign vga.bright     = h_active & v_active;
    assign vga.pix_en     = pix_en_q;
    assign vga.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a reduced-geometry instance exercised across many frames with
// random and targeted resets, plus a full 640x480 instance checked over its first lines.
// Expected outputs come from elapsed clocks since reset via plain arithmetic.
module tb_vga_sync_gen;
    import vga_timing_pkg::*;

    typedef struct packed {
        count_t h;
        count_t v;
        logic   hs;
        logic   vs;
        logic   br;
        logic   pe;
        logic   ft;
        logic   mt;
    } obs_t;

    localparam timing_t SMALL = '{
        h_total: 10'd20, h_sync: 10'd3, h_start: 10'd5, h_end: 10'd17,
        v_total: 10'd12, v_sync: 10'd2, v_start: 10'd3, v_end: 10'd10
    };
    localparam timing_t FULL = VGA_640X480;
    localparam int TF = 4;
    localparam int SMALL_FRAME_CLKS = CLK_DIV * 20 * 12;
    localparam int SMALL_BRIGHT = (17 - 5) * (10 - 3);

    logic clk = 1'b0;
    logic reset_s = 1'b1;
    logic reset_f = 1'b1;

    always #5 clk = ~clk;

    vga_sync_gen_if if_s ();
    vga_sync_gen_if if_f ();

    vga_sync_gen #(.TIMING(SMALL)) dut_s (.clk(clk), .reset(reset_s), .vga(if_s));
    vga_sync_gen #(.TIMING(FULL))  dut_f (.clk(clk), .reset(reset_f), .vga(if_f));

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    obs_t q_s[$];
    obs_t q_f[$];
    int   t_s = 0;
    int   t_f = 0;

    // Output state t clocks after the last reset edge.
    function automatic obs_t model(input int t, input timing_t tm);
        obs_t o;
        int p, ht, vt, fp, h, v;
        ht = int'(tm.h_total);
        vt = int'(tm.v_total);
        fp = ht * vt;
        p  = t / CLK_DIV;
        h  = p % ht;
        v  = (p / ht) % vt;
        o.h  = count_t'(h);
        o.v  = count_t'(v);
        o.hs = (h >= int'(tm.h_sync));
        o.vs = (v >= int'(tm.v_sync));
        o.br = (h >= int'(tm.h_start)) && (h < int'(tm.h_end)) &&
               (v >= int'(tm.v_start)) && (v < int'(tm.v_end));
        o.pe = ((t % CLK_DIV) == CLK_DIV - 1);
        o.ft = ((t % CLK_DIV) == 0) && (p > 0) && ((p % fp) == 0);
`ifdef VGA_MOVE_TICK_EN
        o.mt = o.ft && (((p / fp) % TF) == 0);
`else
        o.mt = 1'b0;
`endif
        return o;
    endfunction

    task automatic check_vec(input string name, input obs_t got, input obs_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            if (miscompares <= 20)
                $display("FAIL %s cyc=%0d got h=%0d v=%0d hs=%b vs=%b br=%b pe=%b ft=%b mt=%b expected h=%0d v=%0d hs=%b vs=%b br=%b pe=%b ft=%b mt=%b",
                         name, cyc, got.h, got.v, got.hs, got.vs, got.br, got.pe, got.ft, got.mt,
                         exp.h, exp.v, exp.hs, exp.vs, exp.br, exp.pe, exp.ft, exp.mt);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got %0d expected %0d", name, cyc, got, exp);
        end
    endtask

    // Reference model: advances with every clock edge, restarts on reset.
    initial begin
        forever begin
            @(posedge clk);
            if (reset_s) t_s = 0; else t_s++;
            q_s.push_back(model(t_s, SMALL));
            if (reset_f) t_f = 0; else t_f++;
            q_f.push_back(model(t_f, FULL));
        end
    end

    // Monitor: pops one expectation per DUT output cycle, plus aggregate timing checks.
    int   last_ft = 0;
    bit   ft_valid = 1'b0;
    int   br_cnt = 0;
    int   hl_cnt = 0;
    bit   hl_track = 1'b0;
    logic prev_hs = 1'b0;

    initial begin
        obs_t got, exp;
        forever begin
            @(negedge clk);
            cyc++;
            if (q_s.size() > 0) begin
                exp = q_s.pop_front();
                got = {if_s.hCount, if_s.vCount, if_s.hSync, if_s.vSync, if_s.bright,
                       if_s.pix_en, if_s.frame_tick, if_s.move_tick};
                check_vec("small", got, exp);
            end
            if (q_f.size() > 0) begin
                exp = q_f.pop_front();
                got = {if_f.hCount, if_f.vCount, if_f.hSync, if_f.vSync, if_f.bright,
                       if_f.pix_en, if_f.frame_tick, if_f.move_tick};
                check_vec("full", got, exp);
            end

            if (reset_s) begin
                ft_valid = 1'b0;
            end else if (if_s.frame_tick === 1'b1) begin
                if (ft_valid) begin
                    check_int("frame_tick_spacing", cyc - last_ft, SMALL_FRAME_CLKS);
                    check_int("bright_strobes_per_frame", br_cnt, SMALL_BRIGHT);
                end
                ft_valid = 1'b1;
                last_ft  = cyc;
                br_cnt   = 0;
            end
            if (if_s.pix_en === 1'b1 && if_s.bright === 1'b1) br_cnt++;

            if (reset_f) begin
                hl_track = 1'b0;
                hl_cnt   = 0;
                prev_hs  = 1'b0;
            end else begin
                if (if_f.hSync === 1'b0) begin
                    if (prev_hs === 1'b1) begin
                        hl_track = 1'b1;
                        hl_cnt   = 0;
                    end
                    hl_cnt++;
                end else if (hl_track) begin
                    check_int("hsync_low_clks", hl_cnt, 384);
                    hl_track = 1'b0;
                end
                prev_hs = if_f.hSync;
            end
        end
    end

    task automatic reset_small(input int n);
        reset_s = 1'b1;
        repeat (n) @(posedge clk);
        #1 reset_s = 1'b0;
    endtask

    initial begin
        fork
            begin : small_seq
                obs_t cur;
                bit   hit;
                repeat (3) @(posedge clk);
                #1 reset_s = 1'b0;
                repeat ($urandom_range(1500, 2500)) @(posedge clk);
                #1 reset_small(1);
                // Targeted mid-frame reset at (10,6).
                hit = 1'b0;
                for (int i = 0; i < 2 * SMALL_FRAME_CLKS && !hit; i++) begin
                    @(posedge clk);
                    #1;
                    cur = model(t_s, SMALL);
                    if (cur.h == 10'd10 && cur.v == 10'd6) hit = 1'b1;
                end
                vectors++;
                if (!hit) begin
                    miscompares++;
                    $display("FAIL target_reset_point cyc=%0d got no (10,6) expected (10,6) within budget", cyc);
                end
                reset_small(1);
                repeat (2) begin
                    repeat ($urandom_range(200, 1200)) @(posedge clk);
                    #1 reset_small($urandom_range(1, 3));
                end
                // Clean tail of more than ten frames.
                repeat (11 * SMALL_FRAME_CLKS) @(posedge clk);
            end
            begin : full_seq
                repeat (3) @(posedge clk);
                #1 reset_f = 1'b0;
                repeat (10200) @(posedge clk);
            end
        join
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
